cpu_trace_checker: RTL and testbench
====================================

Name: cpu_trace_checker

Overview:
- Parametrised successor to the CPU trace-line checker; sits on the simulator's character output stream.
- Consumes one ASCII character per clock and recognises register records "^<time>@<pc>: $<grf> <= <data>#" and memory records "^<time>@<pc>: *<addr> <= <data>#".
- Beyond format recognition, it decodes field values and flags semantic errors: PC range/alignment, address range/alignment, register number, and optionally non-monotonic time.

Parameters:
- TIME_DIGITS, 4: maximum decimal digits in the time field; minimum is 1.
- GRF_DIGITS, 4: maximum decimal digits in the grf field; minimum is 1.
- HEX_DIGITS, 8: exact hex digit count of the pc, addr and data fields. Value width is HW = 4*HEX_DIGITS.
- PC_LO, 32'h0000_3000: lowest legal pc, inclusive.
- PC_HI, 32'h0000_4fff: highest legal pc, inclusive.
- ADDR_HI, 32'h0000_2fff: highest legal memory address, inclusive; lowest is 0.
- GRF_MAX, 31: highest legal register number.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low; asserted when reset==0.
- char  in  8  ASCII input character, sampled every cycle.
- format_type  out  2  2'b01 = register record complete; 2'b10 = memory record complete; 2'b00 otherwise.
- error_code  out  4  semantic error flags for the completed record; 4'b0000 when format_type==0.

Behaviour:
- Registered FSM states: IDLE, CARET, TIME, AT, PC, COLON_SP, DOLLAR, GRF, STAR, ADDR, SP2, LT, EQ_SP, DATA, DONE.
- Transitions:
  - IDLE --'^'--> CARET.
  - CARET --digit--> TIME.
  - TIME --digit--> TIME while the digit count is <= TIME_DIGITS; the (TIME_DIGITS+1)th digit -> IDLE. TIME --'@'--> AT.
  - AT --hex--> PC.
  - PC --hex--> PC. PC --':'--> COLON_SP only when exactly HEX_DIGITS hex digits have been seen.
  - COLON_SP --' '--> COLON_SP; --'$'--> DOLLAR (kind = reg); --'*'--> STAR (kind = mem).
  - DOLLAR --digit--> GRF. GRF --digit--> GRF up to GRF_DIGITS digits; one more digit -> IDLE. GRF --' '--> SP2; --'<'--> LT.
  - STAR --hex--> ADDR. ADDR --' '--> SP2 or --'<'--> LT, only when exactly HEX_DIGITS hex digits have been seen.
  - SP2 --' '--> SP2; --'<'--> LT.
  - LT --'='--> EQ_SP. EQ_SP --' '--> EQ_SP; --hex--> DATA.
  - DATA --hex--> DATA. DATA --'#'--> DONE only when exactly HEX_DIGITS hex digits have been seen.
- From any state, '^' -> CARET and clears all accumulators. This includes IDLE, CARET and DONE.
- Any other character not listed for the current state -> IDLE. Any other character in DONE -> IDLE.
- A (HEX_DIGITS+1)th hex digit in PC, ADDR or DATA -> IDLE.
- Hex digits are '0'-'9' and 'a'-'f' only; uppercase is illegal. Decimal digits are '0'-'9'. Leading zeros are allowed.
- Field accumulation:
  - time and grf: acc = acc*10 + digit, in a register wide enough for 10^DIGITS-1 with no overflow.
  - pc and addr: shift left by 4 and OR in the nibble, HW bits wide.
  - data is counted only, not stored.
- Outputs are decoded from registered state only (Moore). Both outputs are nonzero only while state==DONE, i.e. for exactly one cycle: the cycle after the clock edge that sampled '#'.
- error_code bits, evaluated on the accumulated values while in DONE:
  - bit0: pc[1:0]!=0, or pc<PC_LO, or pc>PC_HI.
  - bit1: memory record and (addr[1:0]!=0 or addr>ADDR_HI). Always 0 for register records.
  - bit2: register record and grf>GRF_MAX. Always 0 for memory records.
  - bit3: time-monotonic error; see Optional Feature.
- Reset: state=IDLE; accumulators, counters and kind cleared; format_type=0 and error_code=0 from the cycle after the reset edge. Reset mid-record discards the partial record.

Optional Feature:
- Macro: CPU_TRACE_TIME_MONO_EN.
- With the macro defined:
  - Registers last_time and a valid flag hold the time of the most recent completed record. They are updated on entry to DONE, whether or not the record has errors.
  - error_code[3]=1 in DONE when valid==1 and the current time < last_time. Equal time is legal.
  - The first record after reset never flags bit3.
  - Reset clears both registers.
- Without the macro: error_code[3] is constant 0; no last_time or valid storage exists.

Test Plan:
- "^10@00003000: $5 <= 0000000f#" -> format_type=01, error_code=0000, one cycle only; the next cycle both outputs are 0.
- "^7@00003004: *00002ffc <= 12345678#" -> format_type=10, error_code=0000. With addr 00003000 -> error_code=0010. With addr 00000002 -> error_code=0010.
- "^1@00002ffc: $32 <= 00000000#" -> format_type=01, error_code=0101 (pc below PC_LO, grf>31). With pc 00003001 -> bit0 set.
- Malformed inputs, each -> format_type stays 00:
  - "^12345@..." (5 time digits).
  - 7-digit pc.
  - Uppercase "00003A00".
  - "<" followed by " =".
  - Then "^^3@00003000:$0<=00000000#" -> format_type=01 (double caret restarts; zero spaces accepted).
- reset driven to 0 for one cycle midway through "^5@00003000: $1" -> the remainder " <= 00000001#" yields 00. A fresh full line afterwards yields 01.
- With CPU_TRACE_TIME_MONO_EN: records with time 20, then 20, then 19 -> error_code[3] = 0, 0, 1. Without the macro, bit3 stays 0 for the same stimulus.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// Trace-line checker: parses "^t@pc: $grf <= data#" / "^t@pc: *addr <= data#" per character.
// Optional CPU_TRACE_TIME_MONO_EN adds a non-monotonic time flag on error_code[3].
module cpu_trace_checker #(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned HEX_DIGITS  = 8,
  parameter int unsigned PC_LO       = 32'h0000_3000,
  parameter int unsigned PC_HI       = 32'h0000_4fff,
  parameter int unsigned ADDR_HI     = 32'h0000_2fff,
  parameter int unsigned GRF_MAX     = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic [1:0] format_type,
  output logic [3:0] error_code
);

  localparam int unsigned HW = 4 * HEX_DIGITS;
  localparam int unsigned TW = $clog2(10 ** TIME_DIGITS);
  localparam int unsigned GW = $clog2(10 ** GRF_DIGITS);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CARET    = 4'd1;
  localparam logic [3:0] TIME     = 4'd2;
  localparam logic [3:0] AT       = 4'd3;
  localparam logic [3:0] PC       = 4'd4;
  localparam logic [3:0] COLON_SP = 4'd5;
  localparam logic [3:0] DOLLAR   = 4'd6;
  localparam logic [3:0] GRF      = 4'd7;
  localparam logic [3:0] STAR     = 4'd8;
  localparam logic [3:0] ADDR     = 4'd9;
  localparam logic [3:0] SP2      = 4'd10;
  localparam logic [3:0] LT       = 4'd11;
  localparam logic [3:0] EQ_SP    = 4'd12;
  localparam logic [3:0] DATA     = 4'd13;
  localparam logic [3:0] DONE     = 4'd14;

  localparam logic [7:0] C_CARET  = 8'h5E;
  localparam logic [7:0] C_AT     = 8'h40;
  localparam logic [7:0] C_COLON  = 8'h3A;
  localparam logic [7:0] C_SP     = 8'h20;
  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_STAR   = 8'h2A;
  localparam logic [7:0] C_LT     = 8'h3C;
  localparam logic [7:0] C_EQ     = 8'h3D;
  localparam logic [7:0] C_HASH   = 8'h23;

  localparam logic [7:0] T_MAX = 8'(TIME_DIGITS);
  localparam logic [7:0] G_MAX = 8'(GRF_DIGITS);
  localparam logic [7:0] H_MAX = 8'(HEX_DIGITS);

  logic [3:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] time_q, time_d;
  logic [GW-1:0] grf_q, grf_d;
  logic [HW-1:0] pc_q, pc_d;
  logic [HW-1:0] addr_q, addr_d;
  logic          kind_q, kind_d;

  logic       dg, hx;
  logic [3:0] nv;

  always_comb begin
    dg = (char >= 8'h30) && (char <= 8'h39);
    hx = dg || ((char >= 8'h61) && (char <= 8'h66));
    nv = dg ? char[3:0] : char[3:0] + 4'd9;
  end

  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    time_d  = time_q;
    grf_d   = grf_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    kind_d  = kind_q;
    if (char == C_CARET) begin
      state_d = CARET;
      cnt_d   = '0;
      time_d  = '0;
      grf_d   = '0;
      pc_d    = '0;
      addr_d  = '0;
      kind_d  = 1'b0;
    end else begin
      unique case (state_q)
        CARET: begin
          if (dg) begin
            state_d = TIME;
            cnt_d   = 8'd1;
            time_d  = TW'(nv);
          end
        end
        TIME: begin
          unique case (1'b1)
            dg && (cnt_q != T_MAX): begin
              state_d = TIME;
              cnt_d   = cnt_q + 8'd1;
              time_d  = TW'(time_q * TW'(10)) + TW'(nv);
            end
            char == C_AT: state_d = AT;
            default: ;
          endcase
        end
        AT: begin
          if (hx) begin
            state_d = PC;
            cnt_d   = 8'd1;
            pc_d    = HW'(nv);
          end
        end
        PC: begin
          unique case (1'b1)
            hx && (cnt_q != H_MAX): begin
              state_d = PC;
              cnt_d   = cnt_q + 8'd1;
              pc_d    = HW'({pc_q, nv});
            end
            (char == C_COLON) && (cnt_q == H_MAX):
              state_d = COLON_SP;
            default: ;
          endcase
        end
        COLON_SP: begin
          unique case (1'b1)
            char == C_SP: state_d = COLON_SP;
            char == C_DOLLAR: begin
              state_d = DOLLAR;
              kind_d  = 1'b0;
            end
            char == C_STAR: begin
              state_d = STAR;
              kind_d  = 1'b1;
            end
            default: ;
          endcase
        end
        DOLLAR: begin
          if (dg) begin
            state_d = GRF;
            cnt_d   = 8'd1;
            grf_d   = GW'(nv);
          end
        end
        GRF: begin
          unique case (1'b1)
            dg && (cnt_q != G_MAX): begin
              state_d = GRF;
              cnt_d   = cnt_q + 8'd1;
              grf_d   = GW'(grf_q * GW'(10)) + GW'(nv);
            end
            char == C_SP: state_d = SP2;
            char == C_LT: state_d = LT;
            default: ;
          endcase
        end
        STAR: begin
          if (hx) begin
            state_d = ADDR;
            cnt_d   = 8'd1;
            addr_d  = HW'(nv);
          end
        end
        ADDR: begin
          unique case (1'b1)
            hx && (cnt_q != H_MAX): begin
              state_d = ADDR;
              cnt_d   = cnt_q + 8'd1;
              addr_d  = HW'({addr_q, nv});
            end
            (char == C_SP) && (cnt_q == H_MAX): state_d = SP2;
            (char == C_LT) && (cnt_q == H_MAX): state_d = LT;
            default: ;
          endcase
        end
        SP2: begin
          unique case (1'b1)
            char == C_SP: state_d = SP2;
            char == C_LT: state_d = LT;
            default: ;
          endcase
        end
        LT: begin
          if (char == C_EQ) state_d = EQ_SP;
        end
        EQ_SP: begin
          unique case (1'b1)
            char == C_SP: state_d = EQ_SP;
            hx: begin
              state_d = DATA;
              cnt_d   = 8'd1;
            end
            default: ;
          endcase
        end
        DATA: begin
          unique case (1'b1)
            hx && (cnt_q != H_MAX): begin
              state_d = DATA;
              cnt_d   = cnt_q + 8'd1;
            end
            (char == C_HASH) && (cnt_q == H_MAX): state_d = DONE;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      time_q  <= '0;
      grf_q   <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      kind_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      grf_q   <= grf_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kind_q  <= kind_d;
    end
  end

  logic mono_err;

`ifdef CPU_TRACE_TIME_MONO_EN
  logic [TW-1:0] last_time_q, last_time_d;
  logic          tvalid_q, tvalid_d;
  logic          mono_q, mono_d;

  // The flag is latched on entry because last_time already holds this record in DONE.
  always_comb begin
    last_time_d = last_time_q;
    tvalid_d    = tvalid_q;
    mono_d      = mono_q;
    if ((state_d == DONE) && (state_q != DONE)) begin
      mono_d      = tvalid_q && (time_q < last_time_q);
      last_time_d = time_q;
      tvalid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_time_q <= '0;
      tvalid_q    <= 1'b0;
      mono_q      <= 1'b0;
    end else begin
      last_time_q <= last_time_d;
      tvalid_q    <= tvalid_d;
      mono_q      <= mono_d;
    end
  end

  assign mono_err = mono_q;
`else
  assign mono_err = 1'b0;
`endif

  always_comb begin
    format_type = 2'b00;
    error_code  = 4'b0000;
    if (state_q == DONE) begin
      format_type   = kind_q ? 2'b10 : 2'b01;
      error_code[0] = (pc_q[1:0] != 2'b00) || (pc_q < HW'(PC_LO))
                      || (pc_q > HW'(PC_HI));
      error_code[1] = kind_q && ((addr_q[1:0] != 2'b00)
                      || (addr_q > HW'(ADDR_HI)));
      error_code[2] = !kind_q && (32'(grf_q) > 32'(GRF_MAX));
      error_code[3] = mono_err;
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: directed lines plus random records vs a field-level model.
// Define CPU_TRACE_TIME_MONO_EN for both bench and design to exercise error_code[3].
module tb_cpu_trace_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char = 8'h00;
  logic [1:0] format_type;
  logic [3:0] error_code;

  int tests = 0;
  int fails = 0;

  int prev_t = 0;
  bit have_prev = 1'b0;

  cpu_trace_checker dut (
    .clk(clk),
    .reset(reset),
    .char(char),
    .format_type(format_type),
    .error_code(error_code)
  );

  always #5 clk = ~clk;

  // Time-order rule: a completed record is flagged if earlier than the previous one.
  function automatic logic mono_exp(input int t);
    logic r;
    r = 1'b0;
`ifdef CPU_TRACE_TIME_MONO_EN
    r = have_prev && (t < prev_t);
`endif
    prev_t = t;
    have_prev = 1'b1;
    return r;
  endfunction

  function automatic string sp(input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, " "};
    return s;
  endfunction

  function automatic logic [3:0] rec_err(input logic [31:0] pc, input bit mem,
                                         input int grf, input logic [31:0] addr);
    logic [3:0] e;
    e[0] = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h4fff);
    e[1] = mem && ((addr % 4 != 0) || (addr > 32'h2fff));
    e[2] = !mem && (grf > 31);
    e[3] = 1'b0;
    return e;
  endfunction

  task automatic send_str(input string s, input logic [1:0] eft,
                          input logic [3:0] eec, input string nm, input bit tail);
    for (int i = 0; i < s.len(); i++) begin
      char = s[i];
      @(posedge clk);
      #1;
      tests++;
      if (i == s.len() - 1) begin
        if (format_type !== eft || error_code !== eec) begin
          fails++;
          $display("FAIL %s: ft=%b ec=%b, expected ft=%b ec=%b",
                   nm, format_type, error_code, eft, eec);
        end
      end else if (format_type !== 2'b00 || error_code !== 4'b0000) begin
        fails++;
        $display("FAIL %s[char %0d]: ft=%b ec=%b, expected 00 0000",
                 nm, i, format_type, error_code);
      end
    end
    if (tail) begin
      char = 8'h0A;
      @(posedge clk);
      #1;
      tests++;
      if (format_type !== 2'b00 || error_code !== 4'b0000) begin
        fails++;
        $display("FAIL %s/next: ft=%b ec=%b, expected 00 0000",
                 nm, format_type, error_code);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    char = 8'h20;
    @(posedge clk);
    #1;
    reset = 1'b1;
    have_prev = 1'b0;
    prev_t = 0;
    tests++;
    if (format_type !== 2'b00 || error_code !== 4'b0000) begin
      fails++;
      $display("FAIL reset: ft=%b ec=%b, expected 00 0000", format_type, error_code);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_reg_record();
    logic m;
    m = mono_exp(10);
    send_str("^10@00003000: $5 <= 0000000f#", 2'b01, {m, 3'b000}, "reg_ok", 1);
    m = mono_exp(1);
    send_str("^1@00002ffc: $32 <= 00000000#", 2'b01, {m, 3'b101}, "reg_pc_grf", 1);
    m = mono_exp(1);
    send_str("^1@00003001: $5 <= 00000000#", 2'b01, {m, 3'b001}, "reg_pc_align", 1);
  endtask

  task automatic test_mem_record();
    logic m;
    m = mono_exp(7);
    send_str("^7@00003004: *00002ffc <= 12345678#", 2'b10, {m, 3'b000}, "mem_ok", 1);
    m = mono_exp(7);
    send_str("^7@00003004: *00003000 <= 12345678#", 2'b10, {m, 3'b010}, "mem_hi", 1);
    m = mono_exp(7);
    send_str("^7@00003004: *00000002 <= 12345678#", 2'b10, {m, 3'b010}, "mem_align", 1);
  endtask

  task automatic test_malformed();
    logic m;
    send_str("^12345@00003000: $5 <= 0000000f#", 2'b00, 4'h0, "bad_time", 1);
    send_str("^1@0003000: $5 <= 0000000f#", 2'b00, 4'h0, "bad_pc7", 1);
    send_str("^1@000030000: $5 <= 0000000f#", 2'b00, 4'h0, "bad_pc9", 1);
    send_str("^1@00003A00: $5 <= 0000000f#", 2'b00, 4'h0, "bad_upper", 1);
    send_str("^1@00003000: $5 < = 0000000f#", 2'b00, 4'h0, "bad_lt_sp", 1);
    send_str("^1@00003000: $00005 <= 0000000f#", 2'b00, 4'h0, "bad_grf5", 1);
    send_str("^1@00003000: *0002ffc <= 0000000f#", 2'b00, 4'h0, "bad_addr7", 1);
    send_str("^1@00003000: $5 <= 000000000#", 2'b00, 4'h0, "bad_data9", 1);
    send_str("^1@00003000: $5 <= 0000000#", 2'b00, 4'h0, "bad_data7", 1);
    m = mono_exp(3);
    send_str("^^3@00003000:$0<=00000000#", 2'b01, {m, 3'b000}, "dbl_caret", 1);
    m = mono_exp(6);
    send_str("^5@00003000: $1 <^6@00003000: $2 <= 00000000#", 2'b01, {m, 3'b000},
             "restart", 1);
  endtask

  task automatic test_mid_reset();
    logic m;
    send_str("^5@00003000: $1", 2'b00, 4'h0, "pre_reset", 0);
    do_reset();
    send_str(" <= 00000001#", 2'b00, 4'h0, "post_reset_tail", 1);
    m = mono_exp(5);
    send_str("^5@00003000: $1 <= 00000001#", 2'b01, {m, 3'b000}, "fresh_line", 1);
  endtask

  task automatic test_time_mono();
    logic m;
    do_reset();
    m = mono_exp(20);
    send_str("^20@00003000: $1 <= 00000001#", 2'b01, {m, 3'b000}, "mono_20a", 1);
    m = mono_exp(20);
    send_str("^20@00003000: $1 <= 00000001#", 2'b01, {m, 3'b000}, "mono_20b", 1);
    m = mono_exp(19);
    send_str("^19@00003000: $1 <= 00000001#", 2'b01, {m, 3'b000}, "mono_19", 1);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      int t, grf;
      bit mem;
      logic [31:0] pc, addr, data;
      logic [3:0] e;
      string s;
      t = $urandom_range(0, 9999);
      mem = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: pc = $urandom;
        1: pc = $urandom_range(32'h2ff0, 32'h3010);
        2: pc = $urandom_range(32'h4ff0, 32'h5010);
        default: pc = 32'h3000 + ($urandom_range(0, 32'h7ff) * 4);
      endcase
      case ($urandom_range(0, 2))
        0: addr = $urandom;
        1: addr = $urandom_range(32'h2ff0, 32'h3010);
        default: addr = $urandom_range(0, 32'hbff) * 4;
      endcase
      grf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9999)
                                        : $urandom_range(0, 40);
      data = $urandom;
      s = $sformatf("^%0d@%08h:", t, pc);
      s = {s, sp($urandom_range(0, 2))};
      if (mem) s = {s, $sformatf("*%08h", addr)};
      else if ($urandom_range(0, 1) == 1) s = {s, $sformatf("$%04d", grf)};
      else s = {s, $sformatf("$%0d", grf)};
      s = {s, sp($urandom_range(0, 2)), "<=", sp($urandom_range(0, 2))};
      s = {s, $sformatf("%08h#", data)};
      e = rec_err(pc, mem, grf, addr);
      e[3] = mono_exp(t);
      send_str(s, mem ? 2'b10 : 2'b01, e, $sformatf("rand%0d", k),
               $urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_reg_record();
    test_mem_record();
    test_malformed();
    test_mid_reset();
    test_time_mono();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
